// File: rtl/bq_pkg.sv
// Shared definitions for the biquad cascade: coefficient slots, FSM states,
// register word offsets and the output saturation helper.
// No logic of its own; imported by bq_mac and bq_cascade.
package bq_pkg;

  // Coefficient slot order inside a section; also the MAC step order.
  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] A1 = 3'd3;
  localparam logic [2:0] A2 = 3'd4;
  localparam int         NCOEF = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_FIN, ST_OUT} state_t;

  // Register offsets as 32-bit word indices (byte offset >> 2).
  localparam logic [5:0] WORD_CTRL   = 6'h00;
  localparam logic [5:0] WORD_STATUS = 6'h01;
  localparam logic [5:0] WORD_COEF   = 6'h10;

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/bq_mac.sv
// Shared signed multiply-accumulate: acc <= (clear ? 0 : acc) +/- sample*coef.
// Latency: one cycle per product; acc_o is the registered running sum.
// No backpressure; accumulates only on cycles where en_i is high.
module bq_mac
  import bq_pkg::*;
#(
  parameter int DW   = 12,
  parameter int CW   = 16,
  parameter int ACCW = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   clear_i,
  input  logic                   sub_i,
  input  logic signed [DW-1:0]   sample_i,
  input  logic signed [CW-1:0]   coef_i,
  output logic signed [ACCW-1:0] acc_o
);

  logic signed [ACCW-1:0] prod;
  logic signed [ACCW-1:0] base;
  logic signed [ACCW-1:0] acc_d;
  logic signed [ACCW-1:0] acc_q;

  // Operands are sign-extended to the accumulator width before multiplying.
  assign prod  = ACCW'(sample_i) * ACCW'(coef_i);
  assign base  = clear_i ? '0 : acc_q;
  assign acc_d = sub_i ? (base - prod) : (base + prod);

  // Accumulator register, updated only while a section is being evaluated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/bq_cascade.sv
// Cascade of SECTIONS DF-I biquads on one shared MAC, coefficients over Wishbone.
// Latency: x_valid to y_valid is 6*SECTIONS+1 cycles; BQ_ROUND_EN selects rounding.
// No input backpressure: x_valid while busy is dropped and flagged; CTRL/coef writes stall while busy.
module bq_cascade
  import bq_pkg::*;
#(
  parameter int          DW        = 12,
  parameter int          CW        = 16,
  parameter int          SECTIONS  = 2,
  parameter int          ACCW      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic          wb_clk_i,
  input  logic          nreset,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic          wb_ack_o,
  output logic [31:0]   wb_dat_o,
  input  logic          x_valid,
  input  logic [DW-1:0] x,
  output logic          y_valid,
  output logic [DW-1:0] y,
  output logic          busy
);

  localparam int SW = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;

  state_t                 state_q;
  logic [SW-1:0]          sec_q;
  logic [2:0]             k_q;
  logic signed [DW-1:0]   x0_q, y_q;
  logic                   y_valid_q;
  logic signed [DW-1:0]   x1_q [SECTIONS];
  logic signed [DW-1:0]   x2_q [SECTIONS];
  logic signed [DW-1:0]   y1_q [SECTIONS];
  logic signed [DW-1:0]   y2_q [SECTIONS];
  logic signed [CW-1:0]   coef_q [SECTIONS][NCOEF];
  logic                   enable_q, sat_q, ovr_q, ack_q;
  logic [31:0]            dat_q;

  logic                   busy_w;
  logic signed [DW-1:0]   operand;
  logic signed [ACCW-1:0] acc, acc_rnd, r_full;
  logic signed [63:0]     sat64;
  logic signed [DW-1:0]   r_sat;
  logic                   clip, sat_set, ovr_set;

  assign busy_w = (state_q != ST_IDLE);

  // ---------------- Wishbone decode ----------------
  logic [5:0]    word, cidx;
  logic [SW-1:0] c_sec;
  logic [2:0]    c_k;
  logic          wb_match, is_ctrl, is_stat, is_coef, stall, accept, wr, clr_hist;
  logic [31:0]   rd_dat;
  logic          unused_bits;

  assign word     = wb_adr_i[7:2];
  assign cidx     = word - WORD_COEF;
  assign c_sec    = cidx[3 +: SW];
  assign c_k      = cidx[2:0];
  assign wb_match = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8] == BASE_ADDR[31:8]);
  assign is_ctrl  = (word == WORD_CTRL);
  assign is_stat  = (word == WORD_STATUS);
  // Only sections that fit in the 256-byte window and exist are mapped.
  assign is_coef  = (word >= WORD_COEF) && (c_k < 3'd5) && (int'(cidx[5:3]) < SECTIONS);
  // Config writes wait for IDLE so coefficients never change mid-sample.
  assign stall    = wb_we_i & busy_w & (is_ctrl | is_coef);
  // Accept at most every other cycle so ack can never be high twice in a row.
  assign accept   = wb_match & ~ack_q & ~stall;
  assign wr       = accept & wb_we_i;
  assign clr_hist = wr & is_ctrl & wb_dat_i[1];
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:CW]};

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    rd_dat = '0;
    if (is_ctrl)      rd_dat = {31'b0, enable_q};
    else if (is_stat) rd_dat = {29'b0, ovr_q, sat_q, busy_w};
    else if (is_coef) rd_dat = 32'(coef_q[c_sec][c_k]);
  end

  // Bus-side registers: ack/data, CTRL, sticky status and coefficient store.
  always_ff @(posedge wb_clk_i or negedge nreset) begin
    if (!nreset) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      enable_q <= 1'b0;
      sat_q    <= 1'b0;
      ovr_q    <= 1'b0;
      for (int s = 0; s < SECTIONS; s++)
        for (int k = 0; k < NCOEF; k++) coef_q[s][k] <= '0;
    end else begin
      ack_q <= accept;
      if (accept && !wb_we_i) dat_q <= rd_dat;
      if (wr && is_ctrl) enable_q <= wb_dat_i[0];
      if (wr && is_coef) coef_q[c_sec][c_k] <= wb_dat_i[CW-1:0];
      if (sat_set)                           sat_q <= 1'b1;
      else if (wr && is_stat && wb_dat_i[1]) sat_q <= 1'b0;
      if (ovr_set)                           ovr_q <= 1'b1;
      else if (wr && is_stat && wb_dat_i[2]) ovr_q <= 1'b0;
    end
  end

  // ---------------- Datapath ----------------
  // Step k picks the history term matching coefficient k of the current section.
  always_comb begin
    operand = x0_q;
    case (k_q)
      B1:      operand = x1_q[sec_q];
      B2:      operand = x2_q[sec_q];
      A1:      operand = y1_q[sec_q];
      A2:      operand = y2_q[sec_q];
      default: operand = x0_q;
    endcase
  end

  bq_mac #(.DW(DW), .CW(CW), .ACCW(ACCW)) u_mac (
    .clk_i    (wb_clk_i),
    .rst_ni   (nreset),
    .en_i     (state_q == ST_MAC),
    .clear_i  (k_q == B0),
    .sub_i    (k_q >= A1),
    .sample_i (operand),
    .coef_i   (coef_q[sec_q][k_q]),
    .acc_o    (acc)
  );

`ifdef BQ_ROUND_EN
  localparam logic signed [ACCW-1:0] RND = ACCW'(1) << (CW - 3);
  assign acc_rnd = acc + RND;
`else
  assign acc_rnd = acc;
`endif

  // Rescale from Q2.(CW-2) products back to sample units, then clamp.
  assign r_full  = acc_rnd >>> (CW - 2);
  assign sat64   = saturate(64'(r_full), DW);
  assign r_sat   = DW'(sat64);
  assign clip    = (sat64 != 64'(r_full));
  assign sat_set = (state_q == ST_FIN) & clip;
  assign ovr_set = x_valid & busy_w;

  // Sequencer: 5 MAC steps + 1 FIN per section, then one OUT cycle.
  always_ff @(posedge wb_clk_i or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      sec_q     <= '0;
      k_q       <= '0;
      x0_q      <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      for (int s = 0; s < SECTIONS; s++) begin
        x1_q[s] <= '0;
        x2_q[s] <= '0;
        y1_q[s] <= '0;
        y2_q[s] <= '0;
      end
    end else begin
      y_valid_q <= 1'b0;
      if (clr_hist) begin
        for (int s = 0; s < SECTIONS; s++) begin
          x1_q[s] <= '0;
          x2_q[s] <= '0;
          y1_q[s] <= '0;
          y2_q[s] <= '0;
        end
      end
      case (state_q)
        ST_IDLE: if (x_valid && enable_q) begin
          x0_q    <= x;
          sec_q   <= '0;
          k_q     <= B0;
          state_q <= ST_MAC;
        end
        ST_MAC: begin
          if (k_q == A2) state_q <= ST_FIN;
          else           k_q     <= k_q + 3'd1;
        end
        ST_FIN: begin
          x2_q[sec_q] <= x1_q[sec_q];
          x1_q[sec_q] <= x0_q;
          y2_q[sec_q] <= y1_q[sec_q];
          y1_q[sec_q] <= r_sat;
          x0_q        <= r_sat;   // section output feeds the next section
          k_q         <= B0;
          if (sec_q == SW'(SECTIONS - 1)) begin
            state_q <= ST_OUT;
          end else begin
            sec_q   <= sec_q + SW'(1);
            state_q <= ST_MAC;
          end
        end
        ST_OUT: begin
          y_q       <= x0_q;
          y_valid_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign y_valid  = y_valid_q;
  assign y        = y_q;
  assign busy     = busy_w;

endmodule
